wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback formatting for the 5-stage MIPS core.
//  Latches MEM-stage results, sign/zero-extends load data and selects the writeback source.
//  Drives the register file write port (a3, WriteData, regWrite, WPC) and the WB forwarding bus.
//  Counts retired instructions for the testbench.
// PARAMETERS
//  PC_RESET  32'h0000_3000  value of WPC and of the latched PC after reset
//  CNT_W     32             width of the retired-instruction counter
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-low reset (0 = reset)
//  stall         in   1   1 = hold the WB register (no capture)
//  flush         in   1   1 = capture a bubble instead of MEM data
//  mem_valid     in   1   MEM stage holds a real instruction
//  mem_pc        in   32  PC of the MEM instruction
//  mem_rd        in   5   destination register
//  mem_regwrite  in   1   instruction writes a GPR
//  mem_wbsel     in   2   0 ALU result, 1 load data, 2 PC+8 (link), 3 HI/LO value
//  mem_alu       in   32  ALU result / effective address
//  mem_hilo      in   32  mfhi/mflo value
//  mem_rdata     in   32  raw aligned word from data memory
//  mem_ldtype    in   3   0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW
//  a3            out  5   GRF write address
//  WriteData     out  32  GRF write data
//  regWrite      out  1   GRF write enable
//  WPC           out  32  PC of the writing instruction (for GRF $display)
//  fwd_en        out  1   WB forwarding valid (equals regWrite)
//  fwd_rd        out  5   WB forwarding register (equals a3)
//  fwd_data      out  32  WB forwarding data (equals WriteData)
//  retired       out  CNT_W  count of valid instructions that left WB
// BEHAVIOUR
//  - Reset (asynchronous, reset==0): valid=0, pc=PC_RESET, rd=0, all data regs 0, retired=0.
//    Outputs read regWrite=0, a3=0, WriteData=0, WPC=PC_RESET until the first capture.
//  - Each posedge with reset==1:
//      flush=1              -> valid<=0; rd, regwrite, data cleared; pc<=mem_pc (flush beats stall)
//      flush=0, stall=1     -> all WB registers hold
//      flush=0, stall=0     -> capture all mem_* inputs; mem_alu[1:0] kept as byte offset
//  - Latency: MEM values present before edge N appear on the GRF port during cycle N+1 and
//    are written into the GRF at edge N+1. The combinational path is latched regs -> format -> outputs.
//  - Load formatting (byte offset off = alu[1:0], little-endian):
//      LB/LBU: byte = rdata[8*off+7 : 8*off]; sign- or zero-extend to 32
//      LH/LHU: half = off[1] ? rdata[31:16] : rdata[15:0]; off[0] is ignored; sign- or zero-extend
//      LW: rdata unchanged
//  - Link: WriteData = pc + 8 (32-bit wrap; 0xFFFF_FFFC + 8 = 0x0000_0004).
//  - regWrite = valid & regwrite & (rd != 0); writes to $0 never reach the GRF.
//  - retired increments by 1 at each edge where stall=0 and valid=1 (the instruction leaves WB).
//    It wraps modulo 2^CNT_W. A flush does not count the bubble. A stall does not double-count.
//  - A reset assertion mid-stream aborts immediately; no write is issued on the edge of deassertion.
// TESTING
//  1 reset low 3 cycles, then release -> regWrite=0, WPC=0x00003000, retired=0
//  2 wbsel=1, ldtype=LB, alu=..2, rdata=0x12F45678 -> WriteData=0xFFFFFFF4; LBU -> 0x000000F4
//  3 wbsel=1, LH, alu=..2, rdata=0x8001_7FFF -> 0xFFFF8001; same with off=3 -> also 0xFFFF8001
//  4 wbsel=2, pc=0x00003010, rd=31 -> a3=31, WriteData=0x00003018, regWrite=1, WPC=0x00003010
//  5 rd=0, regwrite=1, ALU 0x55 -> regWrite=0, fwd_en=0; retired still increments
//  6 stall=1 two cycles with new mem_* -> outputs unchanged, retired +0; flush -> regWrite=0 next cycle

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM->WB stage bundle: stall/flush control, MEM results in, GRF write port and forwarding bus out.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic [31:0]       mem_pc;
  logic [4:0]        mem_rd;
  logic              mem_regwrite;
  logic [1:0]        mem_wbsel;
  logic [31:0]       mem_alu;
  logic [31:0]       mem_hilo;
  logic [31:0]       mem_rdata;
  logic [2:0]        mem_ldtype;

  logic [4:0]        a3;
  logic [31:0]       WriteData;
  logic              regWrite;
  logic [31:0]       WPC;
  logic              fwd_en;
  logic [4:0]        fwd_rd;
  logic [31:0]       fwd_data;
  logic [CNT_W-1:0]  retired;

  modport master (
    output stall, flush, mem_valid, mem_pc, mem_rd, mem_regwrite, mem_wbsel,
           mem_alu, mem_hilo, mem_rdata, mem_ldtype,
    input  a3, WriteData, regWrite, WPC, fwd_en, fwd_rd, fwd_data, retired
  );

  modport slave (
    input  stall, flush, mem_valid, mem_pc, mem_rd, mem_regwrite, mem_wbsel,
           mem_alu, mem_hilo, mem_rdata, mem_ldtype,
    output a3, WriteData, regWrite, WPC, fwd_en, fwd_rd, fwd_data, retired
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB register plus load/link/HI-LO writeback formatting; one cycle from MEM capture to GRF port.
// stall holds every WB register, flush (dominant) loads a bubble; outputs are formatted combinationally.
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2,
    WB_HILO = 2'd3
  } wbsel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ldtype_e;

  logic             valid_q,    valid_d;
  logic [31:0]      pc_q,       pc_d;
  logic [4:0]       rd_q,       rd_d;
  logic             regwrite_q, regwrite_d;
  logic [1:0]       wbsel_q,    wbsel_d;
  logic [31:0]      alu_q,      alu_d;
  logic [31:0]      hilo_q,     hilo_d;
  logic [31:0]      rdata_q,    rdata_d;
  logic [2:0]       ldtype_q,   ldtype_d;
  logic [CNT_W-1:0] retired_q,  retired_d;

  logic             retire_inc;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    wbsel_d    = wbsel_q;
    alu_d      = alu_q;
    hilo_d     = hilo_q;
    rdata_d    = rdata_q;
    ldtype_d   = ldtype_q;

    // The bubble keeps the flushed PC so WPC still tracks program order.
    if (bus.flush) begin
      valid_d    = 1'b0;
      pc_d       = bus.mem_pc;
      rd_d       = 5'd0;
      regwrite_d = 1'b0;
      wbsel_d    = WB_ALU;
      alu_d      = 32'd0;
      hilo_d     = 32'd0;
      rdata_d    = 32'd0;
      ldtype_d   = LD_W;
    end else if (!bus.stall) begin
      valid_d    = bus.mem_valid;
      pc_d       = bus.mem_pc;
      rd_d       = bus.mem_rd;
      regwrite_d = bus.mem_regwrite;
      wbsel_d    = bus.mem_wbsel;
      alu_d      = bus.mem_alu;
      hilo_d     = bus.mem_hilo;
      rdata_d    = bus.mem_rdata;
      ldtype_d   = bus.mem_ldtype;
    end
  end

  // An instruction retires when it is allowed to leave WB, regardless of what replaces it.
  assign retire_inc = valid_q & ~bus.stall;

  always_comb begin
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire_inc};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      pc_q       <= PC_RESET;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      wbsel_q    <= WB_ALU;
      alu_q      <= 32'd0;
      hilo_q     <= 32'd0;
      rdata_q    <= 32'd0;
      ldtype_q   <= LD_W;
      retired_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      wbsel_q    <= wbsel_d;
      alu_q      <= alu_d;
      hilo_q     <= hilo_d;
      rdata_q    <= rdata_d;
      ldtype_q   <= ldtype_d;
      retired_q  <= retired_d;
    end
  end

  logic [1:0]  byte_off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] write_data;
  logic        reg_we;

  assign byte_off = alu_q[1:0];

  always_comb begin
    load_byte = rdata_q[7:0];
    case (byte_off)
      2'd0: load_byte = rdata_q[7:0];
      2'd1: load_byte = rdata_q[15:8];
      2'd2: load_byte = rdata_q[23:16];
      2'd3: load_byte = rdata_q[31:24];
      default: load_byte = rdata_q[7:0];
    endcase
  end

  // Halfword loads ignore the low offset bit; misaligned halves fold onto the aligned one.
  assign load_half = byte_off[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    case (ldtype_q)
      LD_B:    load_data = {{24{load_byte[7]}}, load_byte};
      LD_BU:   load_data = {24'd0, load_byte};
      LD_H:    load_data = {{16{load_half[15]}}, load_half};
      LD_HU:   load_data = {16'd0, load_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    write_data = alu_q;
    case (wbsel_q)
      WB_ALU:  write_data = alu_q;
      WB_LOAD: write_data = load_data;
      WB_LINK: write_data = pc_q + 32'd8;
      WB_HILO: write_data = hilo_q;
      default: write_data = alu_q;
    endcase
  end

  assign reg_we = valid_q & regwrite_q & (rd_q != 5'd0);

  assign bus.a3        = rd_q;
  assign bus.WriteData = write_data;
  assign bus.regWrite  = reg_we;
  assign bus.WPC       = pc_q;
  assign bus.fwd_en    = reg_we;
  assign bus.fwd_rd    = rd_q;
  assign bus.fwd_data  = write_data;
  assign bus.retired   = retired_q;

endmodule
